// File: rtl/wb_write_queue.sv
// In-order register write-back queue with one-hot retire port and read forwarding.
// Define WBQ_FWD_EN to build the pending-write forwarding comparators.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [3:0]    wr_reg,
  input  logic [15:0]   wr_data,
  input  logic          drain_en,
  output logic [15:0]   D,
  output logic [15:0]   WriteReg,
  input  logic [3:0]    SrcReg1,
  input  logic [3:0]    SrcReg2,
  output logic          fwd_hit1,
  output logic [15:0]   fwd_data1,
  output logic          fwd_hit2,
  output logic [15:0]   fwd_data2,
  output logic [AW:0]   count,
  output logic          empty
);

  logic [3:0]    reg_q [DEPTH];
  logic [15:0]   dat_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   d_q, d_d;
  logic [15:0]   we_q, we_d;

  logic full;
  logic push_hs;
  logic enq;
  logic pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign wr_ready = !full;
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign D        = d_q;
  assign WriteReg = we_q;

  // R0 is hardwired zero: handshake completes, nothing is stored
  assign push_hs = wr_valid && wr_ready;
  assign enq     = push_hs && (wr_reg != 4'd0);
  assign pop     = drain_en && !empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    d_d   = d_q;
    we_d  = 16'h0000;
    if (enq) begin
      wp_d = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
      d_d  = dat_q[rp_q];
      we_d = 16'h0001 << reg_q[rp_q];
    end
    unique case (1'b1)
      (enq && !pop): cnt_d = cnt_q + (AW+1)'(1);
      (pop && !enq): cnt_d = cnt_q - (AW+1)'(1);
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      d_q   <= 16'h0000;
      we_q  <= 16'h0000;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      d_q   <= d_d;
      we_q  <= we_d;
    end
  end

  // Payload storage; validity is implied by rp/count
  always_ff @(posedge clk) begin
    if (enq) begin
      reg_q[wp_q] <= wr_reg;
      dat_q[wp_q] <= wr_data;
    end
  end

`ifdef WBQ_FWD_EN
  logic [3:0] oreg_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      oreg_q <= 4'd0;
    end else if (pop) begin
      oreg_q <= reg_q[rp_q];
    end
  end

  // Oldest-to-newest scan so the newest match wins; output stage is lowest priority
  function automatic logic [16:0] lookup(input logic [3:0] src);
    logic          hit;
    logic [15:0]   val;
    logic [AW-1:0] idx;
    hit = (we_q != 16'h0000) && (oreg_q == src);
    val = hit ? d_q : 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + AW'(i);
      if (((AW+1)'(i) < cnt_q) && (reg_q[idx] == src)) begin
        hit = 1'b1;
        val = dat_q[idx];
      end
    end
    if (src == 4'd0) begin
      hit = 1'b0;
      val = 16'h0000;
    end
    return {hit, val};
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(SrcReg1);
    {fwd_hit2, fwd_data2} = lookup(SrcReg2);
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{SrcReg1, SrcReg2};
  assign fwd_hit1   = 1'b0;
  assign fwd_data1  = 16'h0000;
  assign fwd_hit2   = 1'b0;
  assign fwd_data2  = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: queue-level reference model,
// directed scenarios followed by randomized traffic and resets.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_reg = 4'd0;
  logic [15:0] wr_data = 16'h0;
  logic        drain_en = 1'b0;
  logic [15:0] D;
  logic [15:0] WriteReg;
  logic [3:0]  SrcReg1 = 4'd0;
  logic [3:0]  SrcReg2 = 4'd0;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
  logic [AW:0] count;
  logic        empty;

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .drain_en(drain_en),
    .D(D), .WriteReg(WriteReg),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  item_t       mq[$];
  item_t       sb[$];
  bit          out_valid = 1'b0;
  logic [3:0]  out_reg = 4'd0;
  logic [15:0] last_d = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of pending writes plus the last retired entry
  always @(posedge clk) begin : model
    item_t it;
    bit    push_ok;
    if (!rst) begin
      mq.delete();
      sb.delete();
      out_valid = 1'b0;
      out_reg   = 4'd0;
      last_d    = 16'h0;
    end else begin
      push_ok = wr_valid && (mq.size() < DEPTH);
      if (drain_en && mq.size() > 0) begin
        it = mq.pop_front();
        sb.push_back(it);
        out_valid = 1'b1;
        out_reg   = it.r;
        last_d    = it.d;
      end else begin
        out_valid = 1'b0;
      end
      if (push_ok && wr_reg != 4'd0) begin
        it.r = wr_reg;
        it.d = wr_data;
        mq.push_back(it);
      end
    end
  end

  function automatic logic [16:0] fwd_model(input logic [3:0] s);
    logic        h;
    logic [15:0] v;
    h = 1'b0;
    v = 16'h0;
    if (s != 4'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h && mq[i].r == s) begin
          h = 1'b1;
          v = mq[i].d;
        end
      end
      if (!h && out_valid && out_reg == s) begin
        h = 1'b1;
        v = last_d;
      end
    end
    if (!FWD) begin
      h = 1'b0;
      v = 16'h0;
    end
    return {h, v};
  endfunction

  always @(negedge clk) begin : monitor
    item_t       it;
    logic [16:0] e1, e2;
    if (mon_en) begin
      if (WriteReg != 16'h0) begin
        if (sb.size() == 0) begin
          chk("spurious_writereg", {16'h0, WriteReg}, 32'h0);
        end else begin
          it = sb.pop_front();
          chk("writereg", {16'h0, WriteReg}, {16'h0, 16'h1 << it.r});
          chk("retire_d", {16'h0, D}, {16'h0, it.d});
        end
      end else begin
        chk("d_hold", {16'h0, D}, {16'h0, last_d});
      end
      chk("count", {29'h0, count}, mq.size());
      chk("wr_ready", {31'h0, wr_ready}, {31'h0, mq.size() < DEPTH});
      chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
      e1 = fwd_model(SrcReg1);
      e2 = fwd_model(SrcReg2);
      chk("fwd1", {15'h0, fwd_hit1, fwd_data1}, {15'h0, e1});
      chk("fwd2", {15'h0, fwd_hit2, fwd_data2}, {15'h0, e2});
    end
  end

  task automatic step(input logic v, input logic [3:0] r, input logic [15:0] d, input logic dr);
    wr_valid = v;
    wr_reg   = r;
    wr_data  = d;
    drain_en = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'h0, dr);
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b1;
    chk("rst_writereg", {16'h0, WriteReg}, 32'h0);
    chk("rst_d", {16'h0, D}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);

    step(1'b1, 4'd3, 16'hBEEF, 1'b1);
    idle(3, 1'b1);
    chk("t2_count", {29'h0, count}, 32'h0);

    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0);
    chk("t3_full_ready", {31'h0, wr_ready}, 32'h0);
    chk("t3_full_count", {29'h0, count}, 32'h4);
    step(1'b1, 4'd5, 16'h5555, 1'b0);
    chk("t3_refused", {29'h0, count}, 32'h4);
    idle(6, 1'b1);

    step(1'b1, 4'd5, 16'h1111, 1'b0);
    step(1'b1, 4'd5, 16'h2222, 1'b0);
    wr_valid = 1'b0;
    SrcReg1  = 4'd5;
    SrcReg2  = 4'd0;
    #1;
    chk("t4_hit1", {31'h0, fwd_hit1}, {31'h0, FWD});
    chk("t4_data1", {16'h0, fwd_data1}, FWD ? 32'h2222 : 32'h0);
    chk("t4_hit2", {31'h0, fwd_hit2}, 32'h0);
    idle(4, 1'b1);
    SrcReg1 = 4'd0;

    chk("t5_ready", {31'h0, wr_ready}, 32'h1);
    step(1'b1, 4'd0, 16'hFFFF, 1'b1);
    chk("t5_count", {29'h0, count}, 32'h0);
    idle(3, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 4'(6 + i), 16'hA000 + 16'(i), 1'b0);
    rst = 1'b0;
    step(1'b0, 4'd0, 16'h0, 1'b1);
    rst = 1'b1;
    chk("t6_count", {29'h0, count}, 32'h0);
    chk("t6_writereg", {16'h0, WriteReg}, 32'h0);
    idle(6, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      SrcReg1 = 4'($urandom_range(0, 15));
      SrcReg2 = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b1;
    idle(2 * DEPTH + 4, 1'b1);
    chk("final_sb_empty", sb.size(), 32'h0);
    chk("final_q_empty", mq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
